// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection; 1-cycle capture, combinational stall backpressures IF/ID.
// Optional bubble counter enabled by defining STALL_CNT_EN; otherwise stall_cnt is tied to 0.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              startin,
    input  logic [1:0]        ID_wb,
    input  logic [1:0]        ID_m,
    input  logic [3:0]        ID_ex,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_valid,
    input  logic              flush,
    output logic [1:0]        EX_wb,
    output logic [1:0]        EX_m,
    output logic [3:0]        EX_ex,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              ex_valid,
    output logic              stall,
    output logic [31:0]       stall_cnt
);

    logic [1:0]        wb_q, wb_d;
    logic [1:0]        m_q, m_d;
    logic [3:0]        ex_q, ex_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic              valid_q, valid_d;
    logic              hazard;
    logic              bubble;

    // The rt compare is deliberately conservative: it fires even when the
    // consumer ignores rt, trading an occasional spare bubble for simpler decode.
    assign hazard = m_q[1] & valid_q & id_valid & (rt_q != 5'd0) &
                    ((rt_q == id_rs) | (rt_q == id_rt));
    assign stall  = hazard & ~flush;
    assign bubble = flush | hazard;

    always_comb begin
        wb_d    = ID_wb;
        m_d     = ID_m;
        ex_d    = ID_ex;
        rd1_d   = id_rd1;
        rd2_d   = id_rd2;
        imm_d   = id_imm;
        rs_d    = id_rs;
        rt_d    = id_rt;
        rd_d    = id_rd;
        valid_d = id_valid;
        if (bubble) begin
            wb_d    = '0;
            m_d     = '0;
            ex_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            m_q     <= m_d;
            ex_q    <= ex_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    assign EX_wb    = wb_q;
    assign EX_m     = m_q;
    assign EX_ex    = ex_q;
    assign ex_rd1   = rd1_q;
    assign ex_rd2   = rd2_q;
    assign ex_imm   = imm_q;
    assign ex_rs    = rs_q;
    assign ex_rt    = rt_q;
    assign ex_rd    = rd_q;
    assign ex_valid = valid_q;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Only load-use bubbles count; flush bubbles are branch cost, not hazard cost.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              startin;
    logic [1:0]        ID_wb, ID_m;
    logic [3:0]        ID_ex;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_valid, flush;
    logic [1:0]        EX_wb, EX_m;
    logic [3:0]        EX_ex;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_valid, stall;
    logic [31:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction the execute stage should hold, as a record.
    typedef struct {
        logic [1:0]        wb, m;
        logic [3:0]        ex;
        logic [DATA_W-1:0] rd1, rd2, imm;
        logic [4:0]        rs, rt, rd;
        logic              valid;
    } instr_t;

    instr_t      mdl;
    logic [31:0] mdl_cnt;

    id_ex_stage #(.DATA_W(DATA_W)) dut (
        .clk(clk), .startin(startin),
        .ID_wb(ID_wb), .ID_m(ID_m), .ID_ex(ID_ex),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_valid(id_valid), .flush(flush),
        .EX_wb(EX_wb), .EX_m(EX_m), .EX_ex(EX_ex),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t empty_instr();
        instr_t e;
        e.wb = '0; e.m = '0; e.ex = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
        e.rs = '0; e.rt = '0; e.rd = '0; e.valid = 1'b0;
        return e;
    endfunction

    // A load in EX whose destination is read by the decode instruction must wait one cycle.
    function automatic logic model_load_use();
        return mdl.m[1] && mdl.valid && id_valid && (mdl.rt != 0) &&
               (mdl.rt == id_rs || mdl.rt == id_rt);
    endfunction

    task automatic model_reset();
        mdl     = empty_instr();
        mdl_cnt = 32'd0;
    endtask

    task automatic model_edge();
        logic lu;
        lu = model_load_use();
`ifdef STALL_CNT_EN
        if (lu && !flush && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 1;
`endif
        if (flush || lu) begin
            mdl = empty_instr();
        end else begin
            mdl.wb = ID_wb; mdl.m = ID_m; mdl.ex = ID_ex;
            mdl.rd1 = id_rd1; mdl.rd2 = id_rd2; mdl.imm = id_imm;
            mdl.rs = id_rs; mdl.rt = id_rt; mdl.rd = id_rd;
            mdl.valid = id_valid;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ctrl"}, {58'd0, EX_wb, EX_m, EX_ex} , {58'd0, mdl.wb, mdl.m, mdl.ex});
        check({tag, ".rd1"}, {32'd0, ex_rd1}, {32'd0, mdl.rd1});
        check({tag, ".rd2_imm"}, {ex_rd2, ex_imm}, {mdl.rd2, mdl.imm});
        check({tag, ".regs"}, {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, mdl.rs, mdl.rt, mdl.rd});
        check({tag, ".valid"}, {63'd0, ex_valid}, {63'd0, mdl.valid});
        check({tag, ".cnt"}, {32'd0, stall_cnt}, {32'd0, mdl_cnt});
    endtask

    // Called away from the edge with inputs already driven: checks the
    // combinational stall, clocks once, then checks the registered state.
    task automatic tick(input string tag);
        #1;
        check({tag, ".stall"}, {63'd0, stall}, {63'd0, model_load_use() & ~flush});
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic clear_inputs();
        ID_wb = '0; ID_m = '0; ID_ex = '0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [31:0] cnt_before;
        startin = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        check_outputs("reset");
        check("reset.stall", {63'd0, stall}, 64'd0);
        startin = 1'b0;

        // Plain capture
        ID_wb = 2'b10; ID_ex = 4'b1100; id_rd1 = 32'h5; id_valid = 1'b1;
        tick("capture");
        check("capture.wb_const", {62'd0, EX_wb}, 64'd2);
        check("capture.ex_const", {60'd0, EX_ex}, 64'hC);
        check("capture.rd1_const", {32'd0, ex_rd1}, 64'h5);

        // Load-use: lw $8 then add reading $8
        clear_inputs();
        ID_wb = 2'b11; ID_m = 2'b10; id_rt = 5'd8; id_rs = 5'd2; id_valid = 1'b1; id_imm = 32'h40;
        tick("lw");
        clear_inputs();
        ID_wb = 2'b10; ID_ex = 4'b0101; id_rs = 5'd8; id_rt = 5'd3; id_rd = 5'd9;
        id_rd1 = 32'hAAAA; id_rd2 = 32'hBBBB; id_valid = 1'b1;
        #1;
        check("loaduse.stall_const", {63'd0, stall}, 64'd1);
        tick("loaduse.bubble");
        check("loaduse.valid_const", {63'd0, ex_valid}, 64'd0);
        tick("loaduse.release");
        check("loaduse.stall_after", {63'd0, stall}, 64'd0);
`ifdef STALL_CNT_EN
        check("loaduse.cnt_const", {32'd0, stall_cnt}, 64'd1);
`endif

        // $zero destination never stalls
        clear_inputs();
        ID_m = 2'b10; id_rt = 5'd0; id_valid = 1'b1;
        tick("zero.lw");
        clear_inputs();
        ID_wb = 2'b10; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd4; id_rd1 = 32'h77; id_valid = 1'b1;
        tick("zero.use");
        check("zero.valid_const", {63'd0, ex_valid}, 64'd1);

        // Flush wins over a pending hazard and is not counted
        clear_inputs();
        ID_m = 2'b10; id_rt = 5'd8; id_valid = 1'b1;
        tick("flush.lw");
        cnt_before = stall_cnt;
        clear_inputs();
        id_rs = 5'd8; id_valid = 1'b1; flush = 1'b1; id_rd1 = 32'h123;
        tick("flush.bubble");
        check("flush.cnt_same", {32'd0, stall_cnt}, {32'd0, cnt_before});

        // Asynchronous reset mid-cycle while valid
        clear_inputs();
        ID_wb = 2'b01; id_rd1 = 32'hDEAD; id_rd = 5'd7; id_valid = 1'b1;
        tick("arst.load");
        #2;
        startin = 1'b1;
        #1;
        model_reset();
        check_outputs("arst.held");
        #1;
        startin = 1'b0;
        tick("arst.resume");

        // Reset while a load-use stall is pending discards the bubble
        clear_inputs();
        ID_m = 2'b10; id_rt = 5'd5; id_valid = 1'b1;
        tick("arststall.lw");
        clear_inputs();
        id_rt = 5'd5; id_rd1 = 32'h99; ID_wb = 2'b10; id_valid = 1'b1;
        #1;
        check("arststall.pending", {63'd0, stall}, 64'd1);
        startin = 1'b1;
        #1;
        model_reset();
        check("arststall.stall_rst", {63'd0, stall}, 64'd0);
        startin = 1'b0;
        tick("arststall.capture");
        check("arststall.valid_const", {63'd0, ex_valid}, 64'd1);

`ifdef STALL_CNT_EN
        // Saturation
        clear_inputs();
        ID_m = 2'b10; id_rt = 5'd6; id_valid = 1'b1;
        tick("sat.lw");
        clear_inputs();
        id_rs = 5'd6; id_valid = 1'b1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        mdl_cnt = 32'hFFFF_FFFF;
        tick("sat.hazard");
        check("sat.const", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
`endif

        // Randomized traffic with a small register pool to provoke hazards
        for (int i = 0; i < 300; i++) begin
            ID_wb = 2'($urandom);
            ID_m = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
            ID_ex = 4'($urandom);
            id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom);
            id_valid = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of the register-file and immediate fields.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the design's only clock.
REQ-003 SHALL have port startin  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ID_wb  input  2  {reg_write, mem_to_reg} from the decode-stage control unit.
REQ-005 SHALL have port ID_m  input  2  {mem_read, mem_write}.
REQ-006 SHALL have port ID_ex  input  4  {alu_src, alu_op[1:0], reg_dst}.
REQ-007 SHALL have ports id_rd1, id_rd2, id_imm  input  DATA_W  register read data 1/2 and the sign-extended immediate.
REQ-008 SHALL have ports id_rs, id_rt, id_rd  input  5  decode-stage register specifiers.
REQ-009 SHALL have port id_valid  input  1  the decode stage holds a real instruction.
REQ-010 SHALL have port flush  input  1  discard the decode-stage instruction (branch taken).
REQ-011 SHALL have ports EX_wb (2), EX_m (2), EX_ex (4)  output  registered control bundles, same bit order as the inputs.
REQ-012 SHALL have ports ex_rd1, ex_rd2, ex_imm (DATA_W) and ex_rs, ex_rt, ex_rd (5)  output  registered datapath fields.
REQ-013 SHALL have port ex_valid  output  1  the execute stage holds a real instruction.
REQ-014 SHALL have port stall  output  1  combinational; freezes the PC and the IF/ID register.
REQ-015 SHALL have port stall_cnt  output  32  count of load-use bubbles.

Function
REQ-016 SHALL compute hazard = EX_m[1] & ex_valid & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt); the rt compare applies even when the instruction does not use rt.
REQ-017 SHALL drive stall = hazard & ~flush, combinationally, with no registered delay.
REQ-018 SHALL, at each clk edge, apply priority flush > hazard > capture.
REQ-019 SHALL, on flush or hazard, load a bubble: EX_wb, EX_m, EX_ex, ex_valid and all datapath outputs become 0.
REQ-020 SHALL otherwise capture every input into its output register with 1-cycle latency, with ex_valid taking the value of id_valid.
REQ-021 SHALL guarantee that a load-use stall lasts exactly one cycle, because the bubble clears EX_m[1].
REQ-022 SHALL capture a hazard-free instruction that follows a load unchanged, with no extra bubble.
REQ-023 SHALL leave no other state in the block apart from the pipeline register and the optional counter.

Reset
REQ-024 SHALL, while startin=1, force all outputs and stall_cnt to 0 immediately, independent of clk.
REQ-025 SHALL hold stall at 0 during reset, because ex_valid=0.
REQ-026 SHALL, on reset mid-stall, discard the pending bubble; the first edge after release captures the decode-stage inputs normally.

Configuration
REQ-027 SHALL, with macro STALL_CNT_EN defined, increment stall_cnt by 1 on each edge at which a hazard bubble is inserted, not counting flush bubbles, saturating at 32'hFFFFFFFF.
REQ-028 SHALL, with STALL_CNT_EN undefined, keep the stall_cnt port present, drive it constant 0, and synthesise no counter logic.

Verification
REQ-029 SHALL cover capture: ID_wb=2'b10, ID_ex=4'b1100, id_rd1=32'h5, id_valid=1 -> one edge later EX_wb=2'b10, EX_ex=4'b1100, ex_rd1=32'h5, ex_valid=1, stall=0.
REQ-030 SHALL cover load-use: lw with ex_rt=8 in EX (EX_m=2'b10), add with id_rs=8 in ID -> stall=1 same cycle; next edge EX_*=0 and ex_valid=0; stall=0 afterwards; stall_cnt=1 if STALL_CNT_EN.
REQ-031 SHALL cover $zero exemption: lw with ex_rt=0 and id_rs=0 -> stall=0; the instruction is captured normally.
REQ-032 SHALL cover flush over hazard: hazard true and flush=1 -> stall=0; bubble inserted; stall_cnt unchanged.
REQ-033 SHALL cover asynchronous reset: startin pulsed mid-cycle while ex_valid=1 -> all outputs 0 before the next edge; capture resumes after release.
REQ-034 SHALL cover saturation (STALL_CNT_EN): force stall_cnt to 32'hFFFFFFFF, apply a hazard -> value stays 32'hFFFFFFFF.
